// File: rtl/fir_band_sequencer.sv
// Time-multiplexed multi-band FIR controller: one sign-magnitude MAC shared
// across NBANDS bands of ORDER taps, with an owned circular sample history.
module fir_band_sequencer #(
    parameter int ORDER  = 30,
    parameter int NBANDS = 4,
    parameter int ACC_W  = 24,
    localparam int BW = (NBANDS > 1) ? $clog2(NBANDS) : 1,
    localparam int TW = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic          clk_slow,
    input  logic          rst,
    input  logic [15:0]   sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic [BW-1:0] coef_band,
    output logic [TW-1:0] coef_tap,
    input  logic [15:0]   coef_data,
    output logic [15:0]   fir_out,
    output logic          out_valid,
    output logic [BW-1:0] out_band,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic [TW-1:0]    LAST_TAP  = TW'(ORDER - 1);
    localparam logic [BW-1:0]    LAST_BAND = BW'(NBANDS - 1);
    localparam logic [ACC_W-1:0] MAX_MAG   = ACC_W'(16'h7FFF);

    state_t            state, state_nxt;
    logic [15:0]       hist [ORDER];
    logic [TW-1:0]     wr_ptr, newest, tap, idx;
    logic [BW-1:0]     band, band_q;
    logic [ACC_W-1:0]  acc, acc_abs, pext, term;
    logic [15:0]       x, fir_q, fir_sat;
    logic [29:0]       prod;
    logic [14:0]       pmag;
    logic              acc_neg, ovr;

    // Tap 0 is the newest sample; older taps walk backwards and wrap.
    always_comb begin
        if (newest >= tap)
            idx = newest - tap;
        else
            idx = newest - tap + TW'(ORDER);
        x = hist[idx];
    end

    always_comb begin
        prod = {15'b0, x[14:0]} * {15'b0, coef_data[14:0]};
        pmag = 15'(prod >> 15);
        pext = {{(ACC_W-15){1'b0}}, pmag};
        if (x[15] ^ coef_data[15])
            term = {ACC_W{1'b0}} - pext;
        else
            term = pext;
    end

    // Saturating two's-complement to sign-magnitude; zero never gets a sign.
    always_comb begin
        acc_neg = acc[ACC_W-1];
        acc_abs = acc_neg ? ({ACC_W{1'b0}} - acc) : acc;
        if (acc_abs > MAX_MAG)
            fir_sat = {acc_neg, 15'h7FFF};
        else
            fir_sat = {acc_neg, acc_abs[14:0]};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (sample_valid) state_nxt = MAC;
            MAC:  if (tap == LAST_TAP) state_nxt = OUT;
            OUT:  state_nxt = (band == LAST_BAND) ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            newest <= '0;
            tap    <= '0;
            band   <= '0;
            band_q <= '0;
            acc    <= '0;
            fir_q  <= '0;
            ovr    <= 1'b0;
            for (int i = 0; i < ORDER; i++) hist[i] <= '0;
        end else begin
            state <= state_nxt;
            if (sample_valid && state != IDLE) ovr <= 1'b1;
            unique case (state)
                IDLE: if (sample_valid) begin
                    hist[wr_ptr] <= sample_in;
                    newest <= wr_ptr;
                    wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
                    band   <= '0;
                    tap    <= '0;
                    acc    <= '0;
                end
                MAC: begin
                    acc <= acc + term;
                    if (tap != LAST_TAP) tap <= tap + 1'b1;
                end
                OUT: begin
                    fir_q  <= fir_sat;
                    band_q <= band;
                    acc    <= '0;
                    tap    <= '0;
                    if (band != LAST_BAND) band <= band + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sample_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign out_valid    = (state == OUT);
    assign fir_out      = out_valid ? fir_sat : fir_q;
    assign out_band     = out_valid ? band : band_q;
    assign coef_band    = band;
    assign coef_tap     = tap;
    assign overrun      = ovr;

endmodule

// File: tb/tb_fir_band_sequencer.sv
// Randomised and directed bench for fir_band_sequencer, checked every cycle
// against a sample-list reference model of the banded FIR.
module tb_fir_band_sequencer;

    localparam int ORDER  = 30;
    localparam int NBANDS = 4;
    localparam int PER    = ORDER + 1;
    localparam int SPAN   = NBANDS * PER;

    logic        clk_slow = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [1:0]  coef_band;
    logic [4:0]  coef_tap;
    logic [15:0] coef_data;
    logic [15:0] fir_out;
    logic        out_valid;
    logic [1:0]  out_band;
    logic        busy;
    logic        overrun;

    logic [15:0] rom [NBANDS][32];

    fir_band_sequencer dut (
        .clk_slow(clk_slow), .rst(rst),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .coef_band(coef_band), .coef_tap(coef_tap), .coef_data(coef_data),
        .fir_out(fir_out), .out_valid(out_valid), .out_band(out_band),
        .busy(busy), .overrun(overrun)
    );

    assign coef_data = rom[coef_band][coef_tap];

    always #5 clk_slow = ~clk_slow;

    int cyc = 0;
    always @(posedge clk_slow) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted sample since reset, newest last.
    logic [15:0] hq [$];
    logic [15:0] exp_out [NBANDS];
    logic [15:0] dut_last [NBANDS];
    int          out_cyc [NBANDS];
    int          a_cyc = 0;
    bit          have_a = 0;
    bit          m_ovr = 0;
    logic [15:0] last_fir = '0;
    logic [1:0]  last_band = '0;

    function automatic int sm_mul(input logic [15:0] xs, input logic [15:0] cs);
        int m;
        m = (int'(xs[14:0]) * int'(cs[14:0])) / 32768;
        return (xs[15] ^ cs[15]) ? -m : m;
    endfunction

    function automatic logic [15:0] sm_sat(input int s);
        int a;
        if (s == 0) return 16'h0000;
        a = (s < 0) ? -s : s;
        if (a > 32767) a = 32767;
        return {(s < 0), 15'(a)};
    endfunction

    function automatic void model_accept(input logic [15:0] s);
        int sum, k;
        logic [15:0] xv;
        hq.push_back(s);
        for (int b = 0; b < NBANDS; b++) begin
            sum = 0;
            for (int t = 0; t < ORDER; t++) begin
                k = hq.size() - 1 - t;
                xv = (k >= 0) ? hq[k] : 16'h0000;
                sum += sm_mul(xv, rom[b][t]);
            end
            exp_out[b] = sm_sat(sum);
        end
    endfunction

    always @(negedge clk_slow) begin : cmp
        int rel, b, t;
        bit inb, ov;
        if (!rst) begin
            hq.delete();
            have_a = 0;
            m_ovr = 0;
            last_fir = '0;
            last_band = '0;
            chk("rst_ready", sample_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_fir_out", fir_out, 0);
            chk("rst_out_band", out_band, 0);
            chk("rst_coef_band", coef_band, 0);
            chk("rst_coef_tap", coef_tap, 0);
            chk("rst_overrun", overrun, 0);
        end else begin
            rel = cyc - a_cyc;
            inb = have_a && rel >= 1 && rel <= SPAN;
            ov  = inb && (rel % PER == 0);
            chk("busy", busy, inb);
            chk("sample_ready", sample_ready, !inb);
            chk("out_valid", out_valid, ov);
            chk("overrun", overrun, m_ovr);
            if (ov) begin
                b = rel / PER - 1;
                chk("out_band", out_band, b);
                chk("fir_out", fir_out, exp_out[b]);
                last_fir = exp_out[b];
                last_band = 2'(b);
                dut_last[b] = fir_out;
                out_cyc[b] = cyc;
            end else begin
                chk("fir_out_hold", fir_out, last_fir);
                chk("out_band_hold", out_band, last_band);
            end
            if (inb && !ov) begin
                b = (rel - 1) / PER;
                t = (rel - 1) % PER;
                chk("coef_band", coef_band, b);
                chk("coef_tap", coef_tap, t);
            end
            if (sample_valid) begin
                if (inb) begin
                    m_ovr = 1;
                end else begin
                    model_accept(sample_in);
                    a_cyc = cyc;
                    have_a = 1;
                end
            end
        end
    end

    int a_drv = 0;

    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!sample_ready && n < 400) begin
            tick();
            n++;
        end
        chk("wait_idle", sample_ready, 1);
    endtask

    task automatic send(input logic [15:0] s);
        wait_idle();
        sample_in = s;
        sample_valid = 1'b1;
        a_drv = cyc;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_at(input int target);
        while (cyc < target) tick();
        sample_in = 16'($urandom);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic set_rom_const(input logic [15:0] v);
        for (int b = 0; b < NBANDS; b++)
            for (int t = 0; t < 32; t++) rom[b][t] = v;
    endtask

    task automatic run_impulse(input bit check_timing);
        for (int b = 0; b < NBANDS; b++)
            for (int t = 0; t < 32; t++)
                rom[b][t] = (t == b) ? 16'h4000 : 16'h0000;
        for (int k = 0; k < ORDER; k++) begin
            send((k == 0) ? 16'h4000 : 16'h0000);
            wait_idle();
            if (check_timing && k == 0) begin
                chk("ready_return", cyc - a_drv, 125);
                for (int b = 0; b < NBANDS; b++)
                    chk("out_timing", out_cyc[b] - a_drv, 31 * (b + 1));
            end
            for (int b = 0; b < NBANDS; b++)
                chk("impulse", dut_last[b], (k == b) ? 16'h2000 : 16'h0000);
        end
    endtask

    initial begin
        set_rom_const(16'h0000);
        #2 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        run_impulse(1'b1);

        set_rom_const(16'h7FFF);
        repeat (ORDER) send(16'h7FFF);
        wait_idle();
        for (int b = 0; b < NBANDS; b++) chk("sat_pos", dut_last[b], 16'h7FFF);
        repeat (ORDER) send(16'hFFFF);
        wait_idle();
        for (int b = 0; b < NBANDS; b++) chk("sat_neg", dut_last[b], 16'hFFFF);
        for (int k = 0; k < ORDER; k++) send(k[0] ? 16'hC000 : 16'h4000);
        wait_idle();
        for (int b = 0; b < NBANDS; b++) chk("zero_sum", dut_last[b], 16'h0000);

        do_reset();
        set_rom_const(16'h0000);
        for (int b = 0; b < NBANDS; b++) rom[b][ORDER-1] = 16'h7FFF;
        for (int n = 1; n <= 35; n++) begin
            send(16'(n * 256));
            wait_idle();
            chk("hist_wrap", dut_last[0], (n >= 30) ? 16'((n - 29) * 256 - 1) : 16'h0000);
        end

        chk("overrun_clear", overrun, 0);
        for (int b = 0; b < NBANDS; b++)
            for (int t = 0; t < 32; t++) rom[b][t] = 16'($urandom);
        send(16'($urandom));
        pulse_at(a_drv + 10);
        pulse_at(a_drv + 124);
        wait_idle();
        chk("overrun_set", overrun, 1);
        send(16'($urandom));
        wait_idle();
        chk("overrun_sticky", overrun, 1);

        send(16'h1234);
        while (cyc < a_drv + 50) tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", sample_ready, 1);
        chk("abort_valid", out_valid, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (130) tick();
        run_impulse(1'b0);

        for (int b = 0; b < NBANDS; b++)
            for (int t = 0; t < 32; t++) rom[b][t] = 16'($urandom);
        for (int k = 0; k < 20; k++) begin
            send(16'($urandom));
            if ($urandom_range(0, 1) == 1)
                pulse_at(a_drv + int'($urandom_range(2, 124)));
        end
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_band_sequencer.md
Name: fir_band_sequencer

Overview:
- Time-multiplexed controller that shares one 16-bit sign-magnitude Q1.15 multiply-accumulate datapath across NBANDS FIR bands of ORDER taps each.
- Replaces NBANDS parallel ORDER-multiplier transposed chains.
- Owns the sample history buffer, sequences band/tap addressing into an external coefficient ROM, and emits one filtered result per band per accepted input sample.
- Sits between the slow-clock sample source and the band-combining stage.

Parameters:
ORDER, 30, taps per band
NBANDS, 4, number of bands sharing the datapath
ACC_W, 24, internal two's-complement accumulator width (must be >= 16+clog2(ORDER))

Ports:
clk_slow  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
sample_in  input  16  input sample, sign-magnitude Q1.15 (bit15 sign, [14:0] magnitude)
sample_valid  input  1  sample_in is offered this cycle
sample_ready  output  1  block can accept a sample (high only in IDLE)
coef_band  output  clog2(NBANDS)  coefficient ROM band address
coef_tap  output  clog2(ORDER)  coefficient ROM tap address
coef_data  input  16  coefficient, sign-magnitude Q1.15; combinational ROM, valid in the same cycle as its address
fir_out  output  16  band result, sign-magnitude Q1.15
out_valid  output  1  one-cycle strobe qualifying fir_out/out_band
out_band  output  clog2(NBANDS)  band index of the current fir_out
busy  output  1  high in every state except IDLE
overrun  output  1  sticky: sample_valid asserted while sample_ready low; cleared only by reset

Behaviour:
- Reset (rst low, async): state IDLE; history buffer, write pointer, newest pointer, band/tap counters and acc all 0.
- Reset outputs: sample_ready=1, out_valid=0, fir_out=0, out_band=0, coef_band=0, coef_tap=0, busy=0, overrun=0.
- Reset asserted mid-operation aborts immediately. No out_valid is produced for the interrupted sample.
- FSM states are IDLE, MAC, OUT.
- IDLE:
  - sample_ready=1.
  - On sample_valid, the sample is accepted (cycle A): hist[wr_ptr] <= sample_in, newest <= wr_ptr, wr_ptr <= (wr_ptr+1) mod ORDER, band <= 0, tap <= 0, acc <= 0, go to MAC.
- MAC:
  - coef_band=band, coef_tap=tap.
  - Operand x = hist[(newest - tap) mod ORDER]. tap 0 is the newest sample; the index wraps below 0 to ORDER-1.
  - Product magnitude = (|x| * |coef|) >> 15, truncated. Product sign = sign(x) XOR sign(coef). A zero magnitude contributes 0 regardless of sign.
  - acc <= acc ± product (two's complement, ACC_W bits).
  - tap increments. When tap == ORDER-1, the last term is added and the next state is OUT.
- OUT:
  - out_valid=1 for exactly one cycle; out_band=band.
  - fir_out = sign-magnitude conversion of acc, saturated: |acc| > 0x7FFF gives magnitude 0x7FFF with the sign of acc; acc == 0 gives 0x0000 (0x8000 is never output).
  - fir_out and out_band hold their value after the strobe until the next OUT.
  - acc <= 0, tap <= 0.
  - If band == NBANDS-1, go to IDLE; else band <= band+1 and go to MAC.
- Timing (A = accept cycle):
  - MAC for band b occupies cycles A+1+b*(ORDER+1) .. A+ORDER+b*(ORDER+1).
  - out_valid for band b is at A+(b+1)*(ORDER+1).
  - With defaults: band 0 at A+31, band 3 at A+124; IDLE at A+125; the earliest next accept is A+125.
- A sample_valid arriving while busy is dropped and sets overrun. The history and outputs are unaffected.
- A sample_valid in the same cycle that OUT returns to IDLE is not accepted (sample_ready is still low in that cycle) and sets overrun.
- History semantics: until ORDER samples have been accepted, the older entries are the reset value 0.
- Coefficient encoding 0x8000 is treated as +0.

Test Plan:
- Impulse: after reset, accept 0x4000 then ORDER-1 samples of 0x0000. ROM has tap t, band b = 0x4000 for t==b else 0. Required: band b output is 0x2000 only for the sample where the impulse sits at tap b; all other outputs are 0x0000.
- Timing/ordering: accept at cycle A. Required: out_valid at A+31, A+62, A+93, A+124 with out_band 0,1,2,3; sample_ready returns at A+125.
- Sign/saturation: all coefficients 0x7FFF, 30 samples of 0x7FFF give fir_out 0x7FFF on every band. Repeat with samples 0xFFFF: fir_out 0xFFFF. Mixed signs summing to zero: fir_out 0x0000, never 0x8000.
- History wrap: feed ramp samples 1..35 (magnitudes, ×0x0100), only tap 29 coefficient = 0x7FFF. Required: band output tracks the sample 29 acceptances earlier and is 0 for the first 29 samples.
- Overrun: pulse sample_valid at A+10 and at A+124. Required: neither is accepted, overrun=1 and stays 1, outputs are identical to the clean run.
- Reset mid-operation: drop rst at A+50. Required: outputs go to reset values immediately, no further out_valid. After release, an impulse test matches a fresh-reset result (history cleared).
